// File: rtl/soc_system_pio_in_cond_pkg.sv
//==============================================================================
// Module   : soc_system_pio_in_cond_pkg
// Brief    : Shared edge-type encodings and counter-width helper.
// Revision : 1.0
//==============================================================================
`default_nettype none

package soc_system_pio_in_cond_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Bits needed to hold 0..value-1, never less than one so a counter always exists.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_system_pio_in_cond_bit.sv
//==============================================================================
// Module   : soc_system_pio_in_cond_bit
// Brief    : One input lane: 2-flop synchronizer, tick-based debounce,
//            stable flop and sticky edge-capture flag.
// Revision : 1.0
//==============================================================================
`default_nettype none

module soc_system_pio_in_cond_bit
    import soc_system_pio_in_cond_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = 8,
    parameter int   EDGE_TYPE      = EDGE_RISE,
    parameter logic RESET_BIT      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic tick,
    input  logic edge_clr,
    output logic data_out,
    output logic edge_flag
);

    localparam int                  c_CNT_W    = clog2(DEBOUNCE_TICKS);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;
    logic               r_stable_d;
    logic               r_flag;
    logic               w_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= RESET_BIT;
            r_sync2 <= RESET_BIT;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the stable level discards accumulated ticks immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= RESET_BIT;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (tick) begin
            if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_edge = 1'b0;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge = r_stable_d & ~r_stable;
            EDGE_BOTH: w_edge = r_stable_d ^ r_stable;
            default:   w_edge = r_stable & ~r_stable_d;
        endcase
    end

    // The delayed copy resets alongside the stable flop, so reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= RESET_BIT;
            r_flag     <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_flag     <= w_edge | (r_flag & ~edge_clr);
        end
    end

    assign data_out  = r_stable;
    assign edge_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/soc_system_pio_in_cond.sv
//==============================================================================
// Module   : soc_system_pio_in_cond
// Brief    : Conditions asynchronous board inputs for an input PIO: per-bit
//            sync/debounce/edge capture, shared prescaler and masked IRQ.
// Revision : 1.0
//==============================================================================
`default_nettype none

module soc_system_pio_in_cond
    import soc_system_pio_in_cond_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               PRESCALE       = 50000,
    parameter int               DEBOUNCE_TICKS = 8,
    parameter int               EDGE_TYPE      = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] edge_clr,
    input  logic [WIDTH-1:0] irq_mask,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq
);

    localparam int                  c_PRE_W    = clog2(PRESCALE);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_ONE  = c_PRE_W'(1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_tick;
    logic               r_irq;

    // With PRESCALE=1 the counter sits at zero, which is also the last count.
    assign w_tick = (r_pre == c_PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_ONE;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            soc_system_pio_in_cond_bit #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .EDGE_TYPE      (EDGE_TYPE),
                .RESET_BIT      (RESET_VALUE[i])
            ) u_bit (
                .clk       (clk),
                .reset     (reset),
                .raw_in    (raw_in[i]),
                .tick      (w_tick),
                .edge_clr  (edge_clr[i]),
                .data_out  (data_out[i]),
                .edge_flag (edge_flags[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(edge_flags & irq_mask);
        end
    end

    assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_pio_in_cond.sv
//==============================================================================
// Module   : tb_soc_system_pio_in_cond
// Brief    : Self-checking bench for soc_system_pio_in_cond (three configs).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_soc_system_pio_in_cond;
    import soc_system_pio_in_cond_pkg::*;

    localparam int         A_DT = 4;
    localparam logic [7:0] B_RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] raw_a = '0, clr_a = '0, mask_a = '0;
    logic [31:0] data_a, flags_a;
    logic        irq_a;
    logic [7:0]  raw_b = B_RV, clr_b = '0, mask_b = '0;
    logic [7:0]  data_b, flags_b;
    logic        irq_b;
    logic [31:0] raw_c = '0, clr_c = '0, mask_c = '0;
    logic [31:0] data_c, flags_c;
    logic        irq_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    soc_system_pio_in_cond #(.WIDTH(32), .PRESCALE(1), .DEBOUNCE_TICKS(A_DT),
                             .EDGE_TYPE(EDGE_RISE), .RESET_VALUE(32'h0)) dut_a (
        .clk(clk), .reset(reset), .raw_in(raw_a), .edge_clr(clr_a), .irq_mask(mask_a),
        .data_out(data_a), .edge_flags(flags_a), .irq(irq_a));

    soc_system_pio_in_cond #(.WIDTH(8), .PRESCALE(3), .DEBOUNCE_TICKS(4),
                             .EDGE_TYPE(EDGE_BOTH), .RESET_VALUE(B_RV)) dut_b (
        .clk(clk), .reset(reset), .raw_in(raw_b), .edge_clr(clr_b), .irq_mask(mask_b),
        .data_out(data_b), .edge_flags(flags_b), .irq(irq_b));

    soc_system_pio_in_cond #(.WIDTH(32), .PRESCALE(10), .DEBOUNCE_TICKS(2),
                             .EDGE_TYPE(EDGE_RISE), .RESET_VALUE(32'h0)) dut_c (
        .clk(clk), .reset(reset), .raw_in(raw_c), .edge_clr(clr_c), .irq_mask(mask_c),
        .data_out(data_c), .edge_flags(flags_c), .irq(irq_c));

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw_a = '0; clr_a = '0; mask_a = '0;
        raw_b = B_RV; clr_b = '0; mask_b = '0;
        raw_c = '0; clr_c = '0; mask_c = '0;
        repeat (3) clk_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_a = $urandom; raw_b = 8'h3C; raw_c = $urandom; mask_a = '1; mask_c = '1;
        repeat (4) clk_edge();
        n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL reset_data_a: got %h expected %h", data_a, 32'h0); end
        n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL reset_flags_a: got %h expected %h", flags_a, 32'h0); end
        n_tests++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq_a: got %b expected 0", irq_a); end
        n_tests++; if (data_b !== B_RV) begin n_fail++; $display("FAIL reset_data_b: got %h expected %h", data_b, B_RV); end
        n_tests++; if (flags_b !== 8'h0) begin n_fail++; $display("FAIL reset_flags_b: got %h expected 00", flags_b); end
        n_tests++; if (data_c !== 32'h0) begin n_fail++; $display("FAIL reset_data_c: got %h expected %h", data_c, 32'h0); end
    endtask

    task automatic test_latency();
        logic [31:0] exp_d, exp_f;
        do_reset();
        raw_a = 32'h1;
        for (int e = 1; e <= 8; e++) begin
            clk_edge();
            exp_d = (e >= A_DT + 2) ? 32'h1 : 32'h0;
            exp_f = (e >= A_DT + 3) ? 32'h1 : 32'h0;
            n_tests++; if (data_a !== exp_d) begin n_fail++; $display("FAIL latency_data edge %0d: got %h expected %h", e, data_a, exp_d); end
            n_tests++; if (flags_a !== exp_f) begin n_fail++; $display("FAIL latency_flag edge %0d: got %h expected %h", e, flags_a, exp_f); end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        raw_a = 32'h8;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) raw_a = 32'h0;
            clk_edge();
            n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL bounce_data edge %0d: got %h expected %h", e, data_a, 32'h0); end
            n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL bounce_flag edge %0d: got %h expected %h", e, flags_a, 32'h0); end
        end
    endtask

    task automatic test_irq_clear();
        do_reset();
        raw_a = 32'h1;
        repeat (A_DT + 3) clk_edge();
        n_tests++; if (flags_a !== 32'h1) begin n_fail++; $display("FAIL irq_flag_unmasked: got %h expected %h", flags_a, 32'h1); end
        n_tests++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_masked_off: got %b expected 0", irq_a); end
        mask_a = 32'h1;
        clk_edge();
        n_tests++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b expected 1", irq_a); end
        clr_a = 32'h1;
        clk_edge();
        clr_a = 32'h0;
        n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL irq_clr_flag: got %h expected %h", flags_a, 32'h0); end
        n_tests++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_clr_lag: got %b expected 1", irq_a); end
        clk_edge();
        n_tests++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_deassert: got %b expected 0", irq_a); end
        raw_a = 32'h0;
        repeat (A_DT + 4) clk_edge();
        n_tests++; if (data_a !== 32'h0) begin n_fail++; $display("FAIL fall_data: got %h expected %h", data_a, 32'h0); end
        n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL fall_no_rise_flag: got %h expected %h", flags_a, 32'h0); end
    endtask

    task automatic test_set_clr_same();
        do_reset();
        raw_a = 32'h20;
        repeat (A_DT + 2) clk_edge();
        n_tests++; if (data_a !== 32'h20) begin n_fail++; $display("FAIL setclr_data: got %h expected %h", data_a, 32'h20); end
        n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL setclr_preflag: got %h expected %h", flags_a, 32'h0); end
        clr_a = 32'h20;
        clk_edge();
        clr_a = 32'h0;
        n_tests++; if (flags_a !== 32'h20) begin n_fail++; $display("FAIL setclr_same_edge: got %h expected %h", flags_a, 32'h20); end
        clk_edge();
        n_tests++; if (flags_a !== 32'h20) begin n_fail++; $display("FAIL setclr_sticky: got %h expected %h", flags_a, 32'h20); end
        clr_a = 32'h20;
        clk_edge();
        clr_a = 32'h0;
        n_tests++; if (flags_a !== 32'h0) begin n_fail++; $display("FAIL setclr_clear: got %h expected %h", flags_a, 32'h0); end
    endtask

    // Ticks land on edges that are multiples of 10 counted from reset release.
    task automatic test_prescale();
        int s, first, acc, d;
        logic [31:0] exp_d;
        do_reset();
        mask_c = '1;
        raw_c  = '1;
        for (int e = 1; e <= 24; e++) begin
            clk_edge();
            exp_d = (e >= 20) ? '1 : '0;
            n_tests++; if (data_c !== exp_d) begin n_fail++; $display("FAIL prescale_rise edge %0d: got %h expected %h", e, data_c, exp_d); end
            if (e == 21) begin
                n_tests++; if (flags_c !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL prescale_flags: got %h expected ffffffff", flags_c); end
            end
            if (e == 22) begin
                n_tests++; if (irq_c !== 1'b1) begin n_fail++; $display("FAIL prescale_irq: got %b expected 1", irq_c); end
            end
        end
        d = int'($urandom_range(0, 15));
        repeat (d) clk_edge();
        s     = 24 + d + 1;
        first = ((s + 2 + 9) / 10) * 10;
        acc   = first + 10;
        raw_c = '0;
        for (int e = s; e <= acc + 2; e++) begin
            clk_edge();
            exp_d = (e >= acc) ? '0 : '1;
            n_tests++; if (data_c !== exp_d) begin n_fail++; $display("FAIL prescale_fall edge %0d (accept %0d): got %h expected %h", e, acc, data_c, exp_d); end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_d, exp_f;
        do_reset();
        raw_b = ~B_RV;
        for (int e = 1; e <= 7; e++) begin
            clk_edge();
            n_tests++; if (data_b !== B_RV) begin n_fail++; $display("FAIL abort_pre edge %0d: got %h expected %h", e, data_b, B_RV); end
        end
        reset = 1'b1;
        repeat (2) clk_edge();
        reset = 1'b0;
        n_tests++; if (data_b !== B_RV) begin n_fail++; $display("FAIL abort_data: got %h expected %h", data_b, B_RV); end
        n_tests++; if (flags_b !== 8'h0) begin n_fail++; $display("FAIL abort_flags: got %h expected 00", flags_b); end
        for (int e = 1; e <= 13; e++) begin
            clk_edge();
            exp_d = (e >= 12) ? ~B_RV : B_RV;
            exp_f = (e >= 13) ? 8'hFF : 8'h00;
            n_tests++; if (data_b !== exp_d) begin n_fail++; $display("FAIL abort_restart_data edge %0d: got %h expected %h", e, data_b, exp_d); end
            n_tests++; if (flags_b !== exp_f) begin n_fail++; $display("FAIL abort_restart_flags edge %0d: got %h expected %h", e, flags_b, exp_f); end
        end
        n_tests++; if (irq_b !== 1'b0) begin n_fail++; $display("FAIL abort_irq_masked: got %b expected 0", irq_b); end
    endtask

    // Reference: each input is seen two edges late; a bit adopts the seen value once it has
    // disagreed with the stable value for A_DT consecutive edges (a tick every edge here).
    task automatic test_random();
        logic [31:0] hist [$];
        logic [31:0] seen, st, st_prev, fl, nst;
        logic        ir;
        int          run [32];
        do_reset();
        hist = '{32'h0, 32'h0};
        st = '0; st_prev = '0; fl = '0; ir = 1'b0;
        for (int b = 0; b < 32; b++) run[b] = 0;
        for (int c = 0; c < 400; c++) begin
            raw_a  = raw_a ^ ($urandom & $urandom & $urandom & $urandom);
            clr_a  = $urandom & $urandom & $urandom;
            mask_a = $urandom;
            seen = hist[0];
            nst  = st;
            for (int b = 0; b < 32; b++) begin
                if (seen[b] == st[b]) begin
                    run[b] = 0;
                end else begin
                    run[b] = run[b] + 1;
                    if (run[b] == A_DT) begin
                        nst[b] = seen[b];
                        run[b] = 0;
                    end
                end
            end
            ir      = |(fl & mask_a);
            fl      = (st & ~st_prev) | (fl & ~clr_a);
            st_prev = st;
            st      = nst;
            void'(hist.pop_front());
            hist.push_back(raw_a);
            clk_edge();
            n_tests++; if (data_a !== st) begin n_fail++; $display("FAIL random_data cycle %0d: got %h expected %h", c, data_a, st); end
            n_tests++; if (flags_a !== fl) begin n_fail++; $display("FAIL random_flags cycle %0d: got %h expected %h", c, flags_a, fl); end
            n_tests++; if (irq_a !== ir) begin n_fail++; $display("FAIL random_irq cycle %0d: got %b expected %b", c, irq_a, ir); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_irq_clear();
        test_set_clr_same();
        test_prescale();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/soc_system_pio_in_cond.md
SOC_SYSTEM_PIO_IN_COND -- requirements
Module: soc_system_pio_in_cond

Interface
REQ-001 Parameter WIDTH, default 32, number of conditioned input bits.
REQ-002 Parameter PRESCALE, default 50000, clk cycles per debounce tick (1 ms at 50 MHz); legal range 1..2^20.
REQ-003 Parameter DEBOUNCE_TICKS, default 8, consecutive ticks a changed input must hold before acceptance; legal range 1..255.
REQ-004 Parameter EDGE_TYPE, default EDGE_RISE, edge that sets a capture flag (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-005 Parameter RESET_VALUE, default 0, WIDTH-bit reset value of the stable data and synchronizer flops.
REQ-006 clk  input  1  sole clock; one clock domain; reset is synchronous and active-high.
REQ-007 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-008 raw_in  input  WIDTH  asynchronous board inputs (switches, buttons).
REQ-009 edge_clr  input  WIDTH  per-bit write-1-to-clear strobe for edge flags, one cycle wide, from an output PIO.
REQ-010 irq_mask  input  WIDTH  per-bit interrupt enable.
REQ-011 data_out  output  WIDTH  debounced stable value; connects to the input PIO in_port.
REQ-012 edge_flags  output  WIDTH  sticky edge-capture flags.
REQ-013 irq  output  1  registered OR of (edge_flags & irq_mask).

Function
REQ-014 Each raw_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-015 A free-running prescaler counter SHALL count 0..PRESCALE-1, assert tick for one cycle when it equals PRESCALE-1, then wrap to 0; with PRESCALE=1, tick SHALL be high every cycle.
REQ-016 Per bit: if sync2 equals data_out, the bit's debounce counter SHALL be 0 on the next cycle, regardless of tick.
REQ-017 Per bit: if sync2 differs and tick is high and counter < DEBOUNCE_TICKS-1, the counter SHALL increment.
REQ-018 Per bit: if sync2 differs and tick is high and counter == DEBOUNCE_TICKS-1, data_out SHALL take sync2 and the counter SHALL clear to 0 on that edge.
REQ-019 A bounce (sync2 returning to data_out before acceptance) SHALL discard all accumulated ticks.
REQ-020 Latency with PRESCALE=1: a raw_in change sampled on edge 1 SHALL appear on data_out after edge DEBOUNCE_TICKS+2.
REQ-021 An edge flag SHALL set on the cycle after data_out changes in the EDGE_TYPE direction.
REQ-022 edge_clr SHALL clear the corresponding flag on the next edge; simultaneous set and clear SHALL leave the flag set.
REQ-023 irq SHALL be registered, one cycle after edge_flags/irq_mask change; irq_mask SHALL NOT affect edge_flags.
REQ-024 Counters SHALL never exceed DEBOUNCE_TICKS-1 and the prescaler SHALL never exceed PRESCALE-1.

Reset
REQ-025 On reset: sync1, sync2, data_out = RESET_VALUE; debounce counters, prescaler, edge_flags = 0; irq = 0.
REQ-026 Reset asserted mid-debounce SHALL abort the pending acceptance; no edge flag SHALL be produced by reset itself.
REQ-027 The first cycle after reset SHALL behave as prescaler count 0.

Structure
REQ-028 EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 and the counter-width function (clog2) SHALL live in package soc_system_pio_in_cond_pkg.
REQ-029 Per-bit synchronizer, debounce counter, stable flop and edge flag SHALL be sub-module soc_system_pio_in_cond_bit, generated WIDTH times; the prescaler and irq reduction SHALL stay in the top.

Verification
REQ-030 PRESCALE=1, DEBOUNCE_TICKS=4: raw_in[0] 0->1 held -> data_out[0]=1 after edge 6, edge_flags[0]=1 after edge 7.
REQ-031 Same config: raw_in[3] high for 3 cycles then low -> data_out[3] stays 0, edge_flags[3] stays 0.
REQ-032 edge_flags[0]=1, irq_mask=0x1 -> irq=1; pulse edge_clr=0x1 -> edge_flags[0]=0 next edge, irq=0 one edge later.
REQ-033 edge_clr[5] pulsed on the same edge that sets edge_flags[5] -> edge_flags[5]=1.
REQ-034 PRESCALE=10, DEBOUNCE_TICKS=2: raw_in=0xFFFFFFFF held -> data_out=0xFFFFFFFF within 2..3 ticks (20..32 cycles); tick period exactly 10 cycles.
REQ-035 EDGE_TYPE=EDGE_BOTH: reset asserted 2 ticks into a 4-tick debounce -> data_out=RESET_VALUE, edge_flags=0, counters restart from 0 after release.
